// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed seven-segment driver with tear-free frame updates
module seven_segment_scanner #(
    parameter int DIGITS         = 8,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shadow_data, disp_data;
    logic [DIGITS-1:0]     shadow_dp, disp_dp;
    logic                  shadow_blz, disp_blz, pending;
    logic                  tc, boundary;
    logic [3:0]            cur_nib;
    logic                  cur_dp, upper_zero, blank;
    logic [DIGITS-1:0]     an_hot;
    logic [6:0]            seg_lit;

    assign tc       = enable && (presc == P_LAST);
    assign boundary = tc && (idx == I_LAST);

    // prescaler and digit index advance only while scanning, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (enable) begin
            presc <= tc ? '0 : presc + 1'b1;
            if (tc) idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
        end
    end

    // loads land in the shadow; the display copy changes only at a frame boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            shadow_blz  <= 1'b0;
            disp_data   <= '0;
            disp_dp     <= '0;
            disp_blz    <= 1'b0;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                shadow_data <= data;
                shadow_dp   <= dp;
                shadow_blz  <= blank_lz;
            end
            if (boundary && load) begin
                disp_data <= data;
                disp_dp   <= dp;
                disp_blz  <= blank_lz;
            end else if (boundary && pending) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
                disp_blz  <= shadow_blz;
            end
            pending <= !boundary && (pending || load);
        end
    end

    // select the indexed digit and decide whether it is a leading zero
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        upper_zero = 1'b1;
        an_hot     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            an_hot[i] = (IW'(i) == idx);
            if (IW'(i) == idx) begin
                cur_nib = disp_data[4*i +: 4];
                cur_dp  = disp_dp[i];
            end
            if (IW'(i) >= idx && disp_data[4*i +: 4] != 4'h0) upper_zero = 1'b0;
        end
        blank   = disp_blz && (idx != '0) && upper_zero;
        seg_lit = blank ? 7'h00 : HEX7[cur_nib];
    end

    // digit select and segments register on the same edge so they never mismatch
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            an     <= AN_OFF;
            seg    <= SEG_OFF;
            seg_dp <= SEG_ACTIVE_LOW;
        end else begin
            an     <= an_hot ^ AN_OFF;
            seg    <= seg_lit ^ SEG_OFF;
            seg_dp <= cur_dp ^ SEG_ACTIVE_LOW;
        end
        frame_done <= rst_n && boundary;
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: checks two scanner configurations against a frame-level reference model
module tb_seven_segment_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en_a, ld_a, blz_a, en_b, ld_b, blz_b, dp_b, b_rand;
    logic [15:0] data_a;
    logic [3:0]  dp_a, data_b, an_a;
    logic [6:0]  seg_a, seg_b;
    logic        sdp_a, sdp_b, an_b, fd_a, fd_b;

    seven_segment_scanner #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .load(ld_a), .data(data_a), .dp(dp_a),
        .blank_lz(blz_a), .seg(seg_a), .seg_dp(sdp_a), .an(an_a), .frame_done(fd_a)
    );

    seven_segment_scanner #(.DIGITS(1), .CLK_DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .load(ld_b), .data(data_b), .dp(dp_b),
        .blank_lz(blz_b), .seg(seg_b), .seg_dp(sdp_b), .an(an_b), .frame_done(fd_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: scan position counted in enabled cycles within a frame
    logic [6:0]  enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          ndig [2] = '{4, 1};
    int          ndiv [2] = '{4, 1};
    int          ticks [2] = '{0, 0};
    logic [63:0] w_disp [2], w_shad [2];
    logic [15:0] p_disp [2], p_shad [2];
    logic        b_disp [2], b_shad [2], pend [2];
    logic [15:0] e_an [2];
    logic [6:0]  e_seg [2];
    logic        e_dp [2], e_fd [2];

    task automatic model(input int k, input logic en, input logic ld, input logic [63:0] w,
                         input logic [15:0] p, input logic bz);
        int dig, sh;
        logic bnd;
        logic [3:0] nib;
        logic [15:0] allan;
        allan = 16'((32'd1 << ndig[k]) - 1);
        if (!rst_n) begin
            e_an[k] = allan; e_seg[k] = 7'h7F; e_dp[k] = 1'b1; e_fd[k] = 1'b0;
            ticks[k] = 0; pend[k] = 1'b0;
            w_disp[k] = '0; p_disp[k] = '0; b_disp[k] = 1'b0;
            w_shad[k] = '0; p_shad[k] = '0; b_shad[k] = 1'b0;
        end else begin
            dig = ticks[k] / ndiv[k];
            sh = 4 * dig;
            bnd = en && (ticks[k] == ndig[k] * ndiv[k] - 1);
            e_fd[k] = bnd;
            if (en) begin
                nib = 4'(w_disp[k] >> sh);
                e_an[k] = allan & ~(16'd1 << dig);
                e_seg[k] = (b_disp[k] && dig != 0 && (w_disp[k] >> sh) == 64'd0) ? 7'h7F : ~enc[nib];
                e_dp[k] = ~p_disp[k][dig];
            end else begin
                e_an[k] = allan; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
            end
            if (bnd && ld) begin
                w_disp[k] = w; p_disp[k] = p; b_disp[k] = bz;
            end else if (bnd && pend[k]) begin
                w_disp[k] = w_shad[k]; p_disp[k] = p_shad[k]; b_disp[k] = b_shad[k];
            end
            if (ld) begin
                w_shad[k] = w; p_shad[k] = p; b_shad[k] = bz;
            end
            pend[k] = !bnd && (pend[k] || ld);
            if (en) ticks[k] = (ticks[k] + 1) % (ndig[k] * ndiv[k]);
        end
    endtask

    task automatic step();
        if (b_rand) begin
            en_b = ($urandom_range(0, 7) != 0);
            ld_b = ($urandom_range(0, 2) == 0);
            data_b = 4'($urandom);
            dp_b = 1'($urandom);
            blz_b = 1'($urandom);
        end
        model(0, en_a, ld_a, {48'd0, data_a}, {12'd0, dp_a}, blz_a);
        model(1, en_b, ld_b, {60'd0, data_b}, {15'd0, dp_b}, blz_b);
        @(posedge clk);
        #1;
        check("an_a", 32'(an_a), 32'(e_an[0]));
        check("seg_a", 32'(seg_a), 32'(e_seg[0]));
        check("dp_a", 32'(sdp_a), 32'(e_dp[0]));
        check("fd_a", 32'(fd_a), 32'(e_fd[0]));
        check("an_b", 32'(an_b), 32'(e_an[1][0]));
        check("seg_b", 32'(seg_b), 32'(e_seg[1]));
        check("dp_b", 32'(sdp_b), 32'(e_dp[1]));
        check("fd_b", 32'(fd_b), 32'(e_fd[1]));
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    task automatic go_to(input int t);
        for (int i = 0; i < 64 && ticks[0] != t; i++) step();
    endtask

    task automatic load_a(input logic [15:0] d, input logic [3:0] p, input logic bz);
        ld_a = 1'b1; data_a = d; dp_a = p; blz_a = bz;
    endtask

    logic [6:0] lz_seg [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111111};
    logic       lz_dp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        int pulses;
        rst_n = 1'b0; en_a = 1'b0; ld_a = 1'b0; data_a = '0; dp_a = '0; blz_a = 1'b0;
        en_b = 1'b0; ld_b = 1'b0; data_b = '0; dp_b = 1'b0; blz_b = 1'b0; b_rand = 1'b0;
        step();
        step();
        check("rst_an", 32'(an_a), 32'h0000_000F);
        check("rst_seg", 32'(seg_a), 32'h0000_007F);
        check("rst_fd", 32'(fd_a), 32'h0);
        rst_n = 1'b1; en_a = 1'b1; en_b = 1'b1;
        step();
        check("scan_d0_an", 32'(an_a), 32'b1110);
        check("scan_d0_seg", 32'(seg_a), 32'b1000000);
        check("b_an_on", 32'(an_b), 32'h0);
        check("b_fd_every", 32'(fd_b), 32'h1);
        ld_b = 1'b1; data_b = 4'h7;
        step();
        step();
        check("b_tracks_load", 32'(seg_b), 32'h78);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (fd_a) pulses++;
        end
        check("fd_per_32", 32'(pulses), 32'd2);
        b_rand = 1'b1;

        go_to(6);
        load_a(16'h0A3F, 4'b0010, 1'b1);
        step();
        go_to(0);
        for (int d = 0; d < 4; d++) begin
            step();
            check("lz_an", 32'(an_a), 32'(an_exp[d]));
            check("lz_seg", 32'(seg_a), 32'(lz_seg[d]));
            check("lz_dp", 32'(sdp_a), 32'(lz_dp[d]));
            repeat (3) step();
        end

        go_to(3);
        load_a(16'h1111, 4'b0000, 1'b1);
        step();
        go_to(8);
        load_a(16'h2222, 4'b0000, 1'b1);
        step();
        go_to(0);
        step();
        check("latest_wins", 32'(seg_a), 32'b0100100);
        go_to(5);
        load_a(16'h4444, 4'b0000, 1'b0);
        step();
        go_to(15);
        load_a(16'h5555, 4'b0000, 1'b0);
        step();
        step();
        check("bypass", 32'(seg_a), 32'b0010010);
        go_to(0);
        step();
        check("no_stale", 32'(seg_a), 32'b0010010);

        go_to(9);
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("dis_an", 32'(an_a), 32'hF);
            check("dis_seg", 32'(seg_a), 32'h7F);
            check("dis_fd", 32'(fd_a), 32'h0);
        end
        en_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("resume_an", 32'(an_a), 32'b1011);
        end
        step();
        check("resume_next", 32'(an_a), 32'b0111);

        go_to(5);
        load_a(16'h7777, 4'hF, 1'b0);
        step();
        go_to(13);
        rst_n = 1'b0;
        step();
        check("midrst_an", 32'(an_a), 32'hF);
        rst_n = 1'b1;
        step();
        check("restart_an", 32'(an_a), 32'b1110);
        for (int i = 0; i < 32; i++) begin
            step();
            check("pend_dropped", 32'(seg_a), 32'b1000000);
        end

        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en_a = ($urandom_range(0, 9) != 0);
            ld_a = ($urandom_range(0, 11) == 0);
            data_a = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            dp_a = 4'($urandom);
            blz_a = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
